// File: rtl/p_addsub_pipe.sv
// Purpose: multi-lane fixed-point/integer add/subtract with optional saturation and sticky status.
// Latency: 2 cycles from input accept to out_valid; one beat per cycle sustained.
// Backpressure: two-stage valid/ready skid pipeline; in_ready drops only when both stages hold beats.
module p_addsub_pipe #(
    // conf layout: [17] dtype (0 INT, 1 FXP), [16] signed, [15:8] precision, [7:0] fraction bits
    parameter logic [17:0] I1_CONF = {1'b0, 1'b1, 8'd8, 8'd0},
    parameter logic [17:0] I2_CONF = {1'b0, 1'b1, 8'd8, 8'd0},
    parameter logic [17:0] O_CONF  = {1'b0, 1'b1, 8'd8, 8'd0},
    parameter int          LANES   = 4,
    parameter bit          SAT     = 1'b1,
    localparam int I1_PREC = int'(I1_CONF[15:8]),
    localparam int I2_PREC = int'(I2_CONF[15:8]),
    localparam int O_PREC  = int'(O_CONF[15:8])
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          mode,
    input  logic [LANES*I1_PREC-1:0]  in1,
    input  logic [LANES*I2_PREC-1:0]  in2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*O_PREC-1:0]   out,
    output logic [LANES-1:0]          ovf,
    output logic [LANES-1:0]          udf,
    output logic [LANES-1:0]          rounded,
    input  logic                      clr_sticky,
    output logic                      sticky_ovf,
    output logic                      sticky_udf,
    output logic                      sticky_rnd
);

    localparam bit I1_SGN = I1_CONF[16];
    localparam bit I2_SGN = I2_CONF[16];
    localparam bit O_SGN  = O_CONF[16];

    // INT formats carry no fraction, whatever the frac field says
    localparam int I1_FRAC = I1_CONF[17] ? int'(I1_CONF[7:0]) : 0;
    localparam int I2_FRAC = I2_CONF[17] ? int'(I2_CONF[7:0]) : 0;
    localparam int O_FRAC  = O_CONF[17]  ? int'(O_CONF[7:0])  : 0;

    localparam int F12   = (I1_FRAC > I2_FRAC) ? I1_FRAC : I2_FRAC;
    localparam int F     = (F12 > O_FRAC) ? F12 : O_FRAC;
    localparam int I1_SH = F - I1_FRAC;
    localparam int I2_SH = F - I2_FRAC;
    localparam int O_SH  = F - O_FRAC;

    localparam int A1W = I1_PREC + I1_SH;
    localparam int A2W = I2_PREC + I2_SH;
    // two guard bits cover both the carry and an unsigned operand's missing sign bit
    localparam int W   = ((A1W > A2W) ? A1W : A2W) + 2;
    localparam int CW  = (W > O_PREC + 2) ? W : O_PREC + 2;

    localparam logic signed [CW-1:0] OMAX = O_SGN ? CW'({(O_PREC-1){1'b1}}) : CW'({O_PREC{1'b1}});
    localparam logic signed [CW-1:0] OMIN = O_SGN ? ~CW'({(O_PREC-1){1'b1}}) : '0;

    logic                     s1_v;
    logic                     s2_v;
    logic                     s1_load;
    logic                     s2_load;
    logic                     handoff;
    logic [LANES*W-1:0]       s1_sum;
    logic [LANES*W-1:0]       s1_sum_d;
    logic [LANES*O_PREC-1:0]  s2_out_d;
    logic [LANES-1:0]         ovf_d;
    logic [LANES-1:0]         udf_d;
    logic [LANES-1:0]         rnd_d;

    assign s2_load   = s1_v & (~s2_v | out_ready);
    assign in_ready  = ~s1_v | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign handoff   = s2_v & out_ready;
    assign out_valid = s2_v;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [I1_PREC-1:0]   op1;
        logic [I2_PREC-1:0]   op2;
        logic signed [W-1:0]  a1;
        logic signed [W-1:0]  a2;
        logic signed [W-1:0]  r2;
        logic signed [W-1:0]  q2;
        logic signed [CW-1:0] qx;
        logic [O_PREC-1:0]    o;

        assign op1 = in1[k*I1_PREC +: I1_PREC];
        assign op2 = in2[k*I2_PREC +: I2_PREC];

        always_comb begin
            if (I1_SGN) a1 = W'(signed'(op1));
            else        a1 = W'(op1);
            a1 = a1 <<< I1_SH;
            if (I2_SGN) a2 = W'(signed'(op2));
            else        a2 = W'(op2);
            a2 = a2 <<< I2_SH;
        end

        assign s1_sum_d[k*W +: W] = mode[k] ? (a1 - a2) : (a1 + a2);

        // arithmetic shift floors toward -inf, matching truncation of two's complement
        assign r2 = signed'(s1_sum[k*W +: W]);
        assign q2 = r2 >>> O_SH;
        assign qx = CW'(q2);

        assign ovf_d[k] = qx > OMAX;
        assign udf_d[k] = qx < OMIN;

        if (O_SH > 0) begin : g_rnd
            assign rnd_d[k] = |r2[O_SH-1:0];
        end else begin : g_nornd
            assign rnd_d[k] = 1'b0;
        end

        always_comb begin
            if (SAT && ovf_d[k])      o = OMAX[O_PREC-1:0];
            else if (SAT && udf_d[k]) o = OMIN[O_PREC-1:0];
            else                      o = qx[O_PREC-1:0];
        end

        assign s2_out_d[k*O_PREC +: O_PREC] = o;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_sum  <= '0;
            out     <= '0;
            ovf     <= '0;
            udf     <= '0;
            rounded <= '0;
        end else begin
            if (s1_load)      s1_v <= 1'b1;
            else if (s2_load) s1_v <= 1'b0;

            if (s2_load)      s2_v <= 1'b1;
            else if (handoff) s2_v <= 1'b0;

            if (s1_load) s1_sum <= s1_sum_d;

            // stage 2 only reloads when its beat leaves, so a stalled beat stays put
            if (s2_load) begin
                out     <= s2_out_d;
                ovf     <= ovf_d;
                udf     <= udf_d;
                rounded <= rnd_d;
            end
        end
    end

    // a flagged handoff in the clear cycle still sets the sticky bit
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sticky_ovf <= 1'b0;
            sticky_udf <= 1'b0;
            sticky_rnd <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf & ~clr_sticky) | (handoff & |ovf);
            sticky_udf <= (sticky_udf & ~clr_sticky) | (handoff & |udf);
            sticky_rnd <= (sticky_rnd & ~clr_sticky) | (handoff & |rounded);
        end
    end

endmodule
